// File: rtl/taus_urng_ctrl.sv
// taus_urng_ctrl: seeds, warms up and arbitrates two Tausworthe URNGs between two requesters
// Ports: iClk/iRst (async active-low); iCfg_we/iCfg_addr/iCfg_wdata seed writes (IDLE only);
//   iStart/iStop pulses; oSeed1..6 seeds, oGen_rst generator reset; iTaus1/iTaus2 generator words;
//   iReq/oGnt/oValid/oData round-robin word delivery; oBusy not-IDLE; oErr seed error.
// Macro TAUS_SEED_CHECK_EN enables the seed checker; when undefined oErr is tied to 0.
module taus_urng_ctrl #(
  parameter int WARMUP = 16,
  parameter int SEED_RST_CYC = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCfg_we,
  input  logic [2:0]  iCfg_addr,
  input  logic [31:0] iCfg_wdata,
  input  logic        iStart,
  input  logic        iStop,
  output logic [31:0] oSeed1,
  output logic [31:0] oSeed2,
  output logic [31:0] oSeed3,
  output logic [31:0] oSeed4,
  output logic [31:0] oSeed5,
  output logic [31:0] oSeed6,
  output logic        oGen_rst,
  input  logic [31:0] iTaus1,
  input  logic [31:0] iTaus2,
  input  logic [1:0]  iReq,
  output logic [1:0]  oGnt,
  output logic [31:0] oData,
  output logic        oValid,
  output logic        oBusy,
  output logic        oErr
);
  typedef enum logic [1:0] {stIdle, stLoad, stWarm, stRun} stateT;
  stateT state;
  logic [15:0] cnt;
  logic rrPtr, ppPtr, seedBad;
  logic [1:0] gnt;
  // rrPtr names the requester favoured when both ask; it flips to the other after each grant
  assign gnt = (iReq == 2'b11) ? (rrPtr ? 2'b10 : 2'b01) : iReq;
`ifdef TAUS_SEED_CHECK_EN
  // each Tausworthe component needs its seed above 1, 7 or 15 or it degenerates
  assign seedBad = (oSeed1 <= 32'd1) || (oSeed4 <= 32'd1) || (oSeed2 <= 32'd7) ||
                   (oSeed5 <= 32'd7) || (oSeed3 <= 32'd15) || (oSeed6 <= 32'd15);
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) oErr <= 1'b0;
    else oErr <= iCfg_we ? 1'b0 : (state == stIdle && iStart && seedBad) ? 1'b1 : oErr;
`else
  assign seedBad = 1'b0;
  assign oErr = 1'b0;
`endif
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      state <= stIdle;
      oSeed1 <= '0;
      oSeed2 <= '0;
      oSeed3 <= '0;
      oSeed4 <= '0;
      oSeed5 <= '0;
      oSeed6 <= '0;
      oGen_rst <= 1'b1;
      oGnt <= '0;
      oValid <= 1'b0;
      oData <= '0;
      oBusy <= 1'b0;
      rrPtr <= 1'b0;
      ppPtr <= 1'b0;
      cnt <= '0;
    end else begin
      oGnt <= '0;
      oValid <= 1'b0;
      if (state != stIdle && iStop) begin
        state <= stIdle;
        oGen_rst <= 1'b1;
        oBusy <= 1'b0;
        cnt <= '0;
      end else
        case (state)
          stIdle: begin
            if (iCfg_we)
              case (iCfg_addr)
                3'd0: oSeed1 <= iCfg_wdata;
                3'd1: oSeed2 <= iCfg_wdata;
                3'd2: oSeed3 <= iCfg_wdata;
                3'd3: oSeed4 <= iCfg_wdata;
                3'd4: oSeed5 <= iCfg_wdata;
                3'd5: oSeed6 <= iCfg_wdata;
                default: ;
              endcase
            if (iStart && !seedBad) begin
              state <= stLoad;
              oBusy <= 1'b1;
              cnt <= '0;
            end
          end
          stLoad:
            if (cnt == 16'(SEED_RST_CYC - 1)) begin
              cnt <= '0;
              state <= (WARMUP == 0) ? stRun : stWarm;
              oGen_rst <= 1'b0;
            end else cnt <= cnt + 16'd1;
          stWarm:
            if (cnt == 16'(WARMUP - 1)) begin
              cnt <= '0;
              state <= stRun;
            end else cnt <= cnt + 16'd1;
          stRun:
            if (|gnt) begin
              oGnt <= gnt;
              oValid <= 1'b1;
              oData <= ppPtr ? iTaus2 : iTaus1;
              ppPtr <= ~ppPtr;
              rrPtr <= gnt[0];
            end
          default: state <= stIdle;
        endcase
    end
endmodule

// File: tb/tb_taus_urng_ctrl.sv
// tb_taus_urng_ctrl: directed scoreboard bench for taus_urng_ctrl (default and WARMUP=0 instances)
module tb_taus_urng_ctrl;
  logic iClk = 1'b0, iRst = 1'b0, iCfg_we = 1'b0, iStart = 1'b0, iStop = 1'b0;
  logic [2:0] iCfg_addr = '0;
  logic [31:0] iCfg_wdata = '0, iTaus1 = '0, iTaus2 = '0;
  logic [1:0] iReq = '0;
  logic [31:0] oSeed1, oSeed2, oSeed3, oSeed4, oSeed5, oSeed6, oData;
  logic oGen_rst, oValid, oBusy, oErr;
  logic [1:0] oGnt;
  logic [31:0] bSeed1, bSeed2, bSeed3, bSeed4, bSeed5, bSeed6, bData;
  logic bGen_rst, bValid, bBusy, bErr;
  logic [1:0] bGnt;
  int nVec = 0, nErr = 0;
  logic [33:0] sb[$];
  taus_urng_ctrl u0 (
    .iClk(iClk), .iRst(iRst), .iCfg_we(iCfg_we), .iCfg_addr(iCfg_addr), .iCfg_wdata(iCfg_wdata),
    .iStart(iStart), .iStop(iStop), .oSeed1(oSeed1), .oSeed2(oSeed2), .oSeed3(oSeed3),
    .oSeed4(oSeed4), .oSeed5(oSeed5), .oSeed6(oSeed6), .oGen_rst(oGen_rst), .iTaus1(iTaus1),
    .iTaus2(iTaus2), .iReq(iReq), .oGnt(oGnt), .oData(oData), .oValid(oValid), .oBusy(oBusy),
    .oErr(oErr)
  );
  taus_urng_ctrl #(.WARMUP(0)) u1 (
    .iClk(iClk), .iRst(iRst), .iCfg_we(iCfg_we), .iCfg_addr(iCfg_addr), .iCfg_wdata(iCfg_wdata),
    .iStart(iStart), .iStop(iStop), .oSeed1(bSeed1), .oSeed2(bSeed2), .oSeed3(bSeed3),
    .oSeed4(bSeed4), .oSeed5(bSeed5), .oSeed6(bSeed6), .oGen_rst(bGen_rst), .iTaus1(iTaus1),
    .iTaus2(iTaus2), .iReq(iReq), .oGnt(bGnt), .oData(bData), .oValid(bValid), .oBusy(bBusy),
    .oErr(bErr)
  );
  always #5 iClk = ~iClk;
  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask
  task automatic push(input logic [1:0] g, input logic [31:0] d);
    sb.push_back({g, d});
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    iCfg_we = 1'b1;
    iCfg_addr = a;
    iCfg_wdata = d;
    tick();
    iCfg_we = 1'b0;
  endtask
  task automatic seeds();
    wr(3'd0, 32'd2);
    wr(3'd1, 32'd8);
    wr(3'd2, 32'd16);
    wr(3'd3, 32'd3);
    wr(3'd4, 32'd9);
    wr(3'd5, 32'd17);
  endtask
  // start pulse, two LOAD cycles, sixteen WARMUP cycles; returns just after entering RUN with iReq=11
  task automatic startRun(input bit probeB);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("load_busy", 34'(oBusy), 34'd1);
    chk("load_genrst_c1", 34'(oGen_rst), 34'd1);
    tick();
    chk("load_genrst_c2", 34'(oGen_rst), 34'd1);
    tick();
    chk("warm_genrst", 34'(oGen_rst), 34'd0);
    chk("w0_run_genrst", 34'(bGen_rst), 34'd0);
    iReq = 2'b11;
    iTaus1 = 32'hCAFE0001;
    iTaus2 = 32'hCAFE0002;
    if (probeB) begin
      tick();
      chk("w0_first_grant", {bValid, bGnt, bData[30:0]}, {1'b1, 2'b01, 31'h4AFE0001});
      repeat (15) tick();
    end else repeat (16) tick();
  endtask
  // monitor: any valid word must match the oldest expected entry
  always @(posedge iClk) begin
    #2;
    if (oValid) begin
      if (sb.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_grant: got gnt=%b data=%h, required no valid word", oGnt, oData);
      end else chk("grant_word", {oGnt, oData}, sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("rst_seeds", 34'(oSeed1 | oSeed2 | oSeed3 | oSeed4 | oSeed5 | oSeed6), 34'd0);
    chk("rst_outs", {29'd0, oGen_rst, oValid, oBusy, oErr, |oGnt}, {29'd0, 5'b10000});
    chk("rst_data", 34'(oData), 34'd0);
    iRst = 1'b1;
    tick();
    seeds();
    wr(3'd6, 32'hFFFFFFFF);
    chk("seed1", 34'(oSeed1), 34'd2);
    chk("seed2", 34'(oSeed2), 34'd8);
    chk("seed3", 34'(oSeed3), 34'd16);
    chk("seed4", 34'(oSeed4), 34'd3);
    chk("seed5", 34'(oSeed5), 34'd9);
    chk("seed6", 34'(oSeed6), 34'd17);
    chk("idle_genrst", 34'(oGen_rst), 34'd1);
    startRun(1'b1);
    for (int i = 0; i < 6; i++) begin
      iTaus1 = 32'h10000000 + 32'(i);
      iTaus2 = 32'h20000000 + 32'(i);
      push(i[0] ? 2'b10 : 2'b01, i[0] ? iTaus2 : iTaus1);
      tick();
    end
    iReq = 2'b00;
    tick();
    wr(3'd0, 32'h55);
    chk("run_write_ignored", 34'(oSeed1), 34'd2);
    iReq = 2'b01;
    iTaus1 = 32'h33330001;
    iTaus2 = 32'h33330002;
    push(2'b01, 32'h33330001);
    tick();
    #2;
    iRst = 1'b0;
    #1;
    chk("rst_valid_drop", 34'(oValid), 34'd0);
    chk("rst_mid_outs", {31'd0, oGen_rst, oBusy, |oGnt}, {31'd0, 3'b100});
    tick();
    iRst = 1'b1;
    iReq = 2'b00;
    chk("post_rst_seeds", 34'(oSeed1 | oSeed2 | oSeed3 | oSeed4 | oSeed5 | oSeed6), 34'd0);
    seeds();
    startRun(1'b0);
    push(2'b01, 32'hCAFE0001);
    tick();
    push(2'b10, 32'hCAFE0002);
    tick();
    iReq = 2'b00;
    tick();
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    chk("stop_idle", {32'd0, oBusy, oGen_rst}, {32'd0, 2'b01});
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    tick();
    chk("in_warm", {32'd0, oBusy, oGen_rst}, {32'd0, 2'b10});
    iStart = 1'b1;
    iStop = 1'b1;
    tick();
    iStart = 1'b0;
    iStop = 1'b0;
    chk("startstop_idle", {32'd0, oBusy, oGen_rst}, {32'd0, 2'b01});
    tick();
    chk("startstop_stays", 34'(oBusy), 34'd0);
    wr(3'd0, 32'd1);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
`ifdef TAUS_SEED_CHECK_EN
    chk("seed_err_set", {32'd0, oErr, oBusy}, {32'd0, 2'b10});
    tick();
    chk("seed_err_idle", 34'(oBusy), 34'd0);
    wr(3'd0, 32'd5);
    chk("seed_err_clr", 34'(oErr), 34'd0);
`else
    chk("nochk_start", {32'd0, oErr, oBusy}, {32'd0, 2'b01});
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
`endif
    tick();
    chk("sb_drain", 34'(sb.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/taus_urng_ctrl.md
TAUS_URNG_CTRL -- requirements
Module: taus_urng_ctrl

Interface
REQ-001 SHALL have parameter WARMUP, default 16, meaning generator clocks discarded after seeding (0..65535).
REQ-002 SHALL have parameter SEED_RST_CYC, default 2, meaning cycles oGen_rst is held high during seed load (1..15).
REQ-003 SHALL have port iClk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 SHALL have port iCfg_we, input, 1 bit, meaning seed register write strobe.
REQ-006 SHALL have port iCfg_addr, input, 3 bits, meaning seed index 0..5; values 6..7 are ignored.
REQ-007 SHALL have port iCfg_wdata, input, 32 bits, meaning seed write data.
REQ-008 SHALL have ports iStart and iStop, input, 1 bit each, meaning single-cycle start and stop pulses.
REQ-009 SHALL have ports oSeed1..oSeed6, output, 32 bits each, meaning registered seeds to the two generators (1..3 to generator 1, 4..6 to generator 2).
REQ-010 SHALL have port oGen_rst, output, 1 bit, meaning active-high generator reset.
REQ-011 SHALL have ports iTaus1 and iTaus2, input, 32 bits each, meaning generator outputs.
REQ-012 SHALL have port iReq, input, 2 bits, meaning per-requester word requests.
REQ-013 SHALL have port oGnt, output, 2 bits, meaning one-hot grant, valid with oValid.
REQ-014 SHALL have ports oData (32 bits) and oValid (1 bit), outputs, meaning the delivered random word.
REQ-015 SHALL have ports oBusy and oErr, outputs, 1 bit each, meaning not-IDLE and seed error.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WARMUP and RUN.
REQ-017 SHALL accept iCfg_we writes only in IDLE; writes in any other state are ignored.
REQ-018 SHALL move IDLE->LOAD on iStart, unless oErr would be set (REQ-032), in which case it SHALL stay in IDLE.
REQ-019 SHALL assert oGen_rst for exactly SEED_RST_CYC cycles in LOAD, then enter WARMUP.
REQ-020 SHALL count WARMUP cycles in WARMUP, then enter RUN; with WARMUP=0 it SHALL go LOAD->RUN directly.
REQ-021 SHALL, in RUN, grant one requester per cycle among asserted iReq bits, round-robin; with both requesting, grants SHALL alternate 0,1,0,1.
REQ-022 SHALL register the grant: oGnt/oValid/oData appear 1 cycle after the sampled iReq, and oValid=0 with oGnt=0 when no request was granted.
REQ-023 SHALL source oData from a ping-pong pointer, iTaus1 then iTaus2, toggling on every grant and not on idle cycles.
REQ-024 SHALL ignore iReq outside RUN, keeping oValid=0.
REQ-025 SHALL return to IDLE from any non-IDLE state on iStop; if iStop and iStart coincide, iStop wins.
REQ-026 SHALL ignore iStart when not in IDLE.
REQ-027 SHALL drive oBusy=1 in every state except IDLE.

Reset
REQ-028 SHALL, on iRst low, immediately set: state IDLE; oSeed1..6=0; oGen_rst=1; oGnt=0; oValid=0; oData=0; oBusy=0; oErr=0; round-robin pointer favouring requester 0; ping-pong pointer at iTaus1; counters 0.
REQ-029 SHALL keep oGen_rst=1 in IDLE, so the generators run only in LOAD-exit, WARMUP and RUN.
REQ-030 SHALL, when iRst is asserted mid-RUN, drop oValid in the same cycle (asynchronously).

Configuration
REQ-031 SHALL support macro TAUS_SEED_CHECK_EN.
REQ-032 SHALL, with TAUS_SEED_CHECK_EN defined, check seeds on iStart: seeds 1/4 must be >1, seeds 2/5 >7, seeds 3/6 >15; any violation sets oErr=1 and blocks start, and oErr clears on the next iCfg_we.
REQ-033 SHALL, without TAUS_SEED_CHECK_EN, omit the checker, tie oErr to 0, and always start on iStart in IDLE.

Verification
REQ-034 SHALL cover: write seeds 2,8,16,3,9,17 -> iStart -> oGen_rst high 2 cycles -> 16 WARMUP cycles -> RUN.
REQ-035 SHALL cover: iReq=2'b11 held 6 cycles in RUN -> oGnt 01,10,01,10,01,10 with oData iTaus1,iTaus2 alternating.
REQ-036 SHALL cover: with TAUS_SEED_CHECK_EN, seed1=1 -> iStart -> oErr=1, state IDLE; rewrite seed1=5 -> oErr=0.
REQ-037 SHALL cover: iStart and iStop in the same cycle during WARMUP -> IDLE, oBusy=0, oGen_rst=1.
REQ-038 SHALL cover: iRst low mid-RUN with iReq=2'b01 -> oValid=0 immediately; after release, oSeed1..6=0 and a grant to requester 0 occurs first.
REQ-039 SHALL cover: WARMUP=0 -> LOAD goes directly to RUN, and the first grant appears 1 cycle after the RUN request.
